utopia_mphy_rx: RTL

//  Multi-PHY UTOPIA receive engine: polls NUM_PHY PHY cell-available flags round-robin,

---
 rtl/utopia_mphy_rx.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/utopia_mphy_rx.sv
// Multi-PHY UTOPIA receive engine: round-robin PHY polling, 53-byte cell assembly, valid/ready output.
// Optional header check enabled by defining UTOPIA_RX_HEC_CHECK_EN.
module utopia_mphy_rx #(
    parameter int IF_WIDTH = 8,
    parameter int NUM_PHY  = 4,
    parameter int PHY_W    = ($clog2(NUM_PHY) > 0) ? $clog2(NUM_PHY) : 1
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic [NUM_PHY-1:0] phy_clav,
    output logic [NUM_PHY-1:0] phy_en,
    input  logic [IF_WIDTH-1:0] rx_data,
    input  logic               rx_soc,
    output logic [423:0]       cell_data,
    output logic [PHY_W-1:0]   cell_phy,
    output logic               cell_valid,
    input  logic               cell_ready,
    output logic [15:0]        runt_cnt,
    output logic [15:0]        hec_err_cnt
);

    localparam int WORDS = (IF_WIDTH == 16) ? 27 : 53;

    generate
        if (IF_WIDTH != 8 && IF_WIDTH != 16) begin : g_bad_width
            $fatal(1, "utopia_mphy_rx: IF_WIDTH must be 8 or 16");
        end
        if (NUM_PHY < 1 || NUM_PHY > 8) begin : g_bad_phy
            $fatal(1, "utopia_mphy_rx: NUM_PHY must be 1..8");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_POLL,
        ST_READ,
        ST_DONE,
        ST_WAIT
    } state_t;

    state_t             state_reg, state_next;
    logic [PHY_W-1:0]   ptr_reg;
    logic [PHY_W-1:0]   sel_reg;
    logic [5:0]         wcnt_reg, wcnt_next;
    logic [423:0]       asm_reg;
    logic [423:0]       asm_in;
    logic [423:0]       cell_data_reg;
    logic [PHY_W-1:0]   cell_phy_reg;
    logic               cell_valid_reg;
    logic [15:0]        runt_cnt_reg;

    logic               capture, hunt, soc_restart, last_word;
    logic               out_free, load, hec_bad;
    logic               pick_found;
    logic [PHY_W-1:0]   pick_idx;
    logic [PHY_W-1:0]   cand_idx [NUM_PHY];
    logic [NUM_PHY-1:0] cand_hit;

    // Candidate gi is the (gi+1)-th PHY after the pointer, wrapped modulo NUM_PHY.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PHY; gi++) begin : g_rr
            logic [PHY_W:0] sum;
            assign sum          = {1'b0, ptr_reg} + (PHY_W+1)'(gi + 1);
            assign cand_idx[gi] = (sum >= (PHY_W+1)'(NUM_PHY)) ?
                                  PHY_W'(sum - (PHY_W+1)'(NUM_PHY)) : sum[PHY_W-1:0];
            assign cand_hit[gi] = phy_clav[cand_idx[gi]];
            assign phy_en[gi]   = (state_reg == ST_READ) && (sel_reg == PHY_W'(gi));
        end
    endgenerate

    always_comb begin
        pick_found = |cand_hit;
        pick_idx   = '0;
        for (int i = NUM_PHY - 1; i >= 0; i--) begin
            if (cand_hit[i]) pick_idx = cand_idx[i];
        end
    end

    assign capture     = (state_reg == ST_READ);
    assign hunt        = capture && !rx_soc && (wcnt_reg == 6'd0);
    assign soc_restart = capture && rx_soc && (wcnt_reg != 6'd0);
    assign last_word   = capture && !hunt && !soc_restart && (wcnt_reg == 6'(WORDS - 1));

    // On the 16-bit bus word 2 is {HEC,UDF}; only the HEC byte is kept.
    generate
        if (IF_WIDTH == 16) begin : g_w16
            logic [423:0] shift_word, shift_hec;
            assign shift_word = {asm_reg[407:0], rx_data};
            assign shift_hec  = {asm_reg[415:0], rx_data[15:8]};
            assign asm_in     = (wcnt_reg == 6'd2 && !rx_soc) ? shift_hec : shift_word;
        end else begin : g_w8
            assign asm_in = {asm_reg[415:0], rx_data};
        end
    endgenerate

    always_comb begin
        wcnt_next = wcnt_reg + 6'd1;
        if (hunt || last_word) wcnt_next = 6'd0;
        else if (soc_restart)  wcnt_next = 6'd1;
    end

`ifdef UTOPIA_RX_HEC_CHECK_EN
    function automatic logic [7:0] crc8_hdr(input logic [31:0] hdr);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 31; i >= 0; i--) begin
            if (c[7] ^ hdr[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else               c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    logic [15:0] hec_err_cnt_reg;
    assign hec_bad     = (crc8_hdr(asm_reg[423:392]) ^ 8'h55) != asm_reg[391:384];
    assign hec_err_cnt = hec_err_cnt_reg;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            hec_err_cnt_reg <= '0;
        end else if (state_reg == ST_DONE && hec_bad && hec_err_cnt_reg != 16'hFFFF) begin
            hec_err_cnt_reg <= hec_err_cnt_reg + 16'd1;
        end
    end
`else
    assign hec_bad     = 1'b0;
    assign hec_err_cnt = '0;
`endif

    assign out_free = !cell_valid_reg || cell_ready;

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            ST_POLL: if (pick_found) state_next = ST_READ;
            ST_READ: if (last_word)  state_next = ST_DONE;
            ST_DONE: begin
                if (hec_bad) begin
                    state_next = ST_POLL;
                end else if (out_free) begin
                    load       = 1'b1;
                    state_next = ST_POLL;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (out_free) begin
                    load       = 1'b1;
                    state_next = ST_POLL;
                end
            end
            default: state_next = ST_POLL;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_reg      <= ST_POLL;
            ptr_reg        <= PHY_W'(NUM_PHY - 1);
            sel_reg        <= '0;
            wcnt_reg       <= '0;
            cell_data_reg  <= '0;
            cell_phy_reg   <= '0;
            cell_valid_reg <= 1'b0;
            runt_cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_POLL && pick_found) begin
                sel_reg <= pick_idx;
                ptr_reg <= pick_idx;
            end
            if (capture) wcnt_reg <= wcnt_next;
            if (soc_restart && runt_cnt_reg != 16'hFFFF) runt_cnt_reg <= runt_cnt_reg + 16'd1;
            if (load) begin
                cell_data_reg  <= asm_reg;
                cell_phy_reg   <= sel_reg;
                cell_valid_reg <= 1'b1;
            end else if (cell_ready) begin
                cell_valid_reg <= 1'b0;
            end
        end
    end

    // Assembly buffer needs no reset: every delivered cell fully overwrites it.
    always_ff @(posedge clk_in) begin
        if (capture && !hunt) asm_reg <= asm_in;
    end

    assign cell_data  = cell_data_reg;
    assign cell_phy   = cell_phy_reg;
    assign cell_valid = cell_valid_reg;
    assign runt_cnt   = runt_cnt_reg;

endmodule
